// File: rtl/video_capture_ctrl_if.sv
// Pixel stream bundle around the capture sequencer: decoder-side syncs and
// RGB pixels in, tagged/gated pixels out.
interface video_capture_ctrl_if;
    logic       iVS;
    logic       iHS;
    logic [9:0] iR;
    logic [9:0] iG;
    logic [9:0] iB;
    logic       iDVAL;
    logic [9:0] oR;
    logic [9:0] oG;
    logic [9:0] oB;
    logic       oDVAL;
    logic [9:0] oX;
    logic [8:0] oY;
    logic       oSOF;
    logic       oEOL;
    logic       oEOF;

    // Source of decoder pixels and sink of captured pixels.
    modport master (
        output iVS, iHS, iR, iG, iB, iDVAL,
        input  oR, oG, oB, oDVAL, oX, oY, oSOF, oEOL, oEOF
    );

    // Capture sequencer side.
    modport slave (
        input  iVS, iHS, iR, iG, iB, iDVAL,
        output oR, oG, oB, oDVAL, oX, oY, oSOF, oEOL, oEOF
    );
endinterface

// File: rtl/video_capture_ctrl.sv
// Frame-capture sequencer: gates the free-running RGB stream into whole,
// aligned fields on request, tags pixels with x/y and SOF/EOL/EOF markers,
// skips fields when the consumer is not ready and flags truncated lines/fields.
module video_capture_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 240,
    parameter int CNT_W    = 8
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic                 iStart,
    input  logic                 iStop,
    input  logic                 iContinuous,
    input  logic                 iReady,
    video_capture_ctrl_if.slave  vid,
    output logic                 oBusy,
    output logic                 oDone,
    output logic                 oErrShortLine,
    output logic                 oErrShortFrame,
    output logic [CNT_W-1:0]     oDropCnt
);
    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, FLUSH} state_t;

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);
    localparam logic [8:0] Y_END  = 9'(V_ACTIVE);

    // Dropped-field counter holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    state_t           state_q;
    logic             vs_q, hs_q;
    logic             cont_q, stop_q;
    logic [9:0]       x_q;
    logic [8:0]       y_q;
    logic [9:0]       r_q, g_q, b_q;
    logic             dval_q;
    logic [9:0]       ox_q;
    logic [8:0]       oy_q;
    logic             sof_q, eol_q, eof_q, done_q;
    logic             err_line_q, err_frame_q;
    logic [CNT_W-1:0] drop_q;

    logic       vs_fall, hs_fall, stop_now;
    logic       short_line, eol_pix, eof_pix;
    logic [9:0] x_cur;
    logic [8:0] y_cur;

    assign vs_fall  = vs_q & ~vid.iVS;
    assign hs_fall  = hs_q & ~vid.iHS;
    assign stop_now = stop_q | iStop;

    // Coordinates seen by this cycle's pixel once a line sync has been applied.
    always_comb begin
        short_line = hs_fall && (x_q != '0);
        x_cur      = short_line ? '0 : x_q;
        y_cur      = short_line ? y_q + 9'd1 : y_q;
        eol_pix    = (x_cur == X_LAST);
        eof_pix    = eol_pix && (y_cur == Y_LAST);
    end

    // Registered copies of the active-low syncs for falling-edge detection.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            vs_q <= 1'b0;
            hs_q <= 1'b0;
        end else begin
            vs_q <= vid.iVS;
            hs_q <= vid.iHS;
        end
    end

    // Capture FSM with all outputs registered alongside the pixel.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q     <= IDLE;
            cont_q      <= 1'b0;
            stop_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            dval_q      <= 1'b0;
            ox_q        <= '0;
            oy_q        <= '0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            done_q      <= 1'b0;
            err_line_q  <= 1'b0;
            err_frame_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            dval_q <= 1'b0;
            sof_q  <= 1'b0;
            eol_q  <= 1'b0;
            eof_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (iStart) begin
                        state_q     <= WAIT_VS;
                        cont_q      <= iContinuous;
                        stop_q      <= 1'b0;
                        err_line_q  <= 1'b0;
                        err_frame_q <= 1'b0;
                        drop_q      <= '0;
                    end
                end
                WAIT_VS: begin
                    if (iStop) begin
                        state_q <= IDLE;
                    end else if (vs_fall) begin
                        if (iReady) begin
                            state_q <= ACTIVE;
                            x_q     <= '0;
                            y_q     <= '0;
                        end else begin
                            drop_q <= sat_inc(drop_q);
                        end
                    end
                end
                ACTIVE: begin
                    if (iStop) stop_q <= 1'b1;
                    if (vs_fall) begin
                        // New field arrived before this one finished: abort it.
                        err_frame_q <= 1'b1;
                        done_q      <= 1'b1;
                        if (cont_q && !stop_now) begin
                            if (iReady) begin
                                x_q <= '0;
                                y_q <= '0;
                            end else begin
                                state_q <= WAIT_VS;
                                drop_q  <= sat_inc(drop_q);
                            end
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        if (short_line) err_line_q <= 1'b1;
                        if (y_cur == Y_END) begin
                            // Line syncs alone have used up the field.
                            done_q  <= 1'b1;
                            state_q <= (cont_q && !stop_now) ? WAIT_VS : IDLE;
                        end else if (vid.iDVAL) begin
                            r_q    <= vid.iR;
                            g_q    <= vid.iG;
                            b_q    <= vid.iB;
                            dval_q <= 1'b1;
                            ox_q   <= x_cur;
                            oy_q   <= y_cur;
                            sof_q  <= (x_cur == '0) && (y_cur == '0);
                            eol_q  <= eol_pix;
                            eof_q  <= eof_pix;
                            if (eol_pix) begin
                                x_q <= '0;
                                y_q <= y_cur + 9'd1;
                            end else begin
                                x_q <= x_cur + 10'd1;
                                y_q <= y_cur;
                            end
                            if (eof_pix) begin
                                if (stop_now) begin
                                    state_q <= FLUSH;
                                end else begin
                                    done_q  <= 1'b1;
                                    state_q <= cont_q ? WAIT_VS : IDLE;
                                end
                            end
                        end else begin
                            x_q <= x_cur;
                            y_q <= y_cur;
                        end
                    end
                end
                FLUSH: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vid.oR         = r_q;
    assign vid.oG         = g_q;
    assign vid.oB         = b_q;
    assign vid.oDVAL      = dval_q;
    assign vid.oX         = ox_q;
    assign vid.oY         = oy_q;
    assign vid.oSOF       = sof_q;
    assign vid.oEOL       = eol_q;
    assign vid.oEOF       = eof_q;
    assign oBusy          = (state_q != IDLE);
    assign oDone          = done_q;
    assign oErrShortLine  = err_line_q;
    assign oErrShortFrame = err_frame_q;
    assign oDropCnt       = drop_q;
endmodule

// File: tb/tb_video_capture_ctrl.sv
// Testbench for video_capture_ctrl on a shrunken 8x4 field with a 2-bit
// drop counter. Each stimulus task records which output cycle must carry
// which pixel (coordinates from its own loop indices) and where oDone must
// pulse; every cycle the outputs are compared against that record.
`timescale 1ns/1ps
module tb_video_capture_ctrl;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst, start, stop, cont, ready;
    logic          busy, done, err_line, err_frame;
    logic [CW-1:0] drop;

    video_capture_ctrl_if vid();

    video_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(CW)) dut (
        .iCLK(clk), .iRESET(rst), .iStart(start), .iStop(stop),
        .iContinuous(cont), .iReady(ready), .vid(vid),
        .oBusy(busy), .oDone(done), .oErrShortLine(err_line),
        .oErrShortFrame(err_frame), .oDropCnt(drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         x;
        int         y;
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } pix_t;

    pix_t exp_pix [int];
    bit   exp_done [int];
    int   now = 0;
    bit   chk_en = 1'b0;
    int   n_tests = 0, n_fail = 0;
    int   n_pix = 0, n_sof = 0, n_eol = 0, n_eof = 0, n_done = 0;
    int   s_pix, s_sof, s_eol, s_eof, s_done;

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Compare this cycle's outputs with the recorded expectations.
    task automatic cycle_check();
        bit   ev, ed, bad;
        pix_t e;
        e  = '{0, 0, 10'd0, 10'd0, 10'd0};
        ev = exp_pix.exists(now);
        ed = exp_done.exists(now);
        if (ev) e = exp_pix[now];
        bad = (vid.oDVAL !== ev) || (done !== ed);
        if (!bad && ev)
            bad = (vid.oX !== 10'(e.x)) || (vid.oY !== 9'(e.y)) ||
                  (vid.oR !== e.r) || (vid.oG !== e.g) || (vid.oB !== e.b) ||
                  (vid.oSOF !== (e.x == 0 && e.y == 0)) ||
                  (vid.oEOL !== (e.x == H - 1)) ||
                  (vid.oEOF !== (e.x == H - 1 && e.y == V - 1));
        if (!bad && !ev)
            bad = (vid.oSOF !== 1'b0) || (vid.oEOL !== 1'b0) || (vid.oEOF !== 1'b0);
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL stream cyc %0d: got dval=%b done=%b x=%0d y=%0d rgb=%h/%h/%h sof/eol/eof=%b%b%b; want dval=%b done=%b x=%0d y=%0d rgb=%h/%h/%h",
                     now, vid.oDVAL, done, vid.oX, vid.oY, vid.oR, vid.oG, vid.oB,
                     vid.oSOF, vid.oEOL, vid.oEOF, ev, ed, e.x, e.y, e.r, e.g, e.b);
        end
        if (vid.oDVAL === 1'b1) begin
            n_pix++;
            if (vid.oSOF === 1'b1) n_sof++;
            if (vid.oEOL === 1'b1) n_eol++;
            if (vid.oEOF === 1'b1) n_eof++;
        end
        if (done === 1'b1) n_done++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        now++;
        if (chk_en) cycle_check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_pix(input int x, input int y, input bit cap,
                            input bit done_here, input bit hs);
        logic [9:0] r, g, b;
        r = 10'(x * 7 + y * 64 + 1);
        g = 10'((x << 4) ^ y ^ 'h2A5);
        b = 10'(1023 - x * 3 - y);
        vid.iR    = r;
        vid.iG    = g;
        vid.iB    = b;
        vid.iDVAL = 1'b1;
        if (hs) vid.iHS = 1'b0;
        if (cap) exp_pix[now + 1] = '{x, y, r, g, b};
        if (done_here) exp_done[now + 1] = 1'b1;
        step();
        vid.iDVAL = 1'b0;
        vid.iHS   = 1'b1;
    endtask

    task automatic vsync();
        vid.iVS = 1'b0;
        step();
        vid.iVS = 1'b1;
        step();
    endtask

    task automatic hsync();
        vid.iHS = 1'b0;
        step();
        vid.iHS = 1'b1;
        step();
    endtask

    task automatic line(input int y, input bit cap, input int n, input bit done_last);
        hsync();
        for (int x = 0; x < n; x++) send_pix(x, y, cap, done_last && x == n - 1, 1'b0);
    endtask

    task automatic field(input bit cap, input bit done_at_eof);
        for (int y = 0; y < V; y++) line(y, cap, H, done_at_eof && y == V - 1);
    endtask

    task automatic pulse_start(input bit c, input bit with_stop);
        start = 1'b1;
        cont  = c;
        stop  = with_stop;
        step();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic snap();
        s_pix = n_pix; s_sof = n_sof; s_eol = n_eol; s_eof = n_eof; s_done = n_done;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; ready = 1'b1;
        vid.iVS = 1'b1; vid.iHS = 1'b1; vid.iDVAL = 1'b0;
        vid.iR = '0; vid.iG = '0; vid.iB = '0;
        idle(3);
        rst = 1'b0;
        chk_en = 1'b1;
        step();
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset errline", err_line, 0);
        chk("reset errframe", err_frame, 0);
        chk("reset dropcnt", drop, 0);
        chk("reset dval", vid.oDVAL, 0);
        chk("reset x", vid.oX, 0);
        chk("reset eof", vid.oEOF, 0);

        // Single shot; start and stop together: start wins.
        pulse_start(1'b0, 1'b1);
        chk("t1 busy after start", busy, 1);
        snap();
        idle(2);
        vsync();
        field(1'b1, 1'b1);
        step();
        chk("t1 busy after field", busy, 0);
        chk("t1 pixels", n_pix - s_pix, H * V);
        chk("t1 sof", n_sof - s_sof, 1);
        chk("t1 eol", n_eol - s_eol, V);
        chk("t1 eof", n_eof - s_eof, 1);
        chk("t1 done", n_done - s_done, 1);
        send_pix(1, 1, 1'b0, 1'b0, 1'b0);
        vsync();
        line(0, 1'b0, 4, 1'b0);

        // Continuous with three unready field starts, then capture.
        ready = 1'b0;
        pulse_start(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            vsync();
            line(0, 1'b0, 3, 1'b0);
        end
        chk("t2 dropcnt", drop, 3);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t2 start ignored", drop, 3);
        ready = 1'b1;
        snap();
        vsync();
        field(1'b1, 1'b1);
        step();
        chk("t2 sof", n_sof - s_sof, 1);
        chk("t2 busy waiting", busy, 1);
        pulse_stop();
        chk("t2 stop in wait", busy, 0);

        // Saturating drop counter, cleared by start.
        ready = 1'b0;
        pulse_start(1'b1, 1'b0);
        chk("t2b dropcnt cleared", drop, 0);
        for (int i = 0; i < 5; i++) vsync();
        chk("t2b dropcnt saturated", drop, 3);
        pulse_stop();
        chk("t2b busy", busy, 0);
        ready = 1'b1;

        // Short line, then a pixel that coincides with a line sync.
        pulse_start(1'b0, 1'b0);
        chk("t3 errline cleared", err_line, 0);
        vsync();
        line(0, 1'b1, H - 2, 1'b0);
        hsync();
        chk("t3 errline set", err_line, 1);
        for (int x = 0; x < 3; x++) send_pix(x, 1, 1'b1, 1'b0, 1'b0);
        send_pix(0, 2, 1'b1, 1'b0, 1'b1);
        for (int x = 1; x < H; x++) send_pix(x, 2, 1'b1, 1'b0, 1'b0);
        line(3, 1'b1, H, 1'b1);
        step();
        chk("t3 busy", busy, 0);
        chk("t3 errframe", err_frame, 0);

        // Line sync that pushes the line count past the field ends it.
        pulse_start(1'b0, 1'b0);
        chk("t4 errline cleared", err_line, 0);
        vsync();
        for (int y = 0; y < V - 1; y++) line(y, 1'b1, H, 1'b0);
        line(V - 1, 1'b1, 5, 1'b0);
        vid.iHS = 1'b0;
        exp_done[now + 1] = 1'b1;
        step();
        vid.iHS = 1'b1;
        step();
        chk("t4 busy", busy, 0);
        chk("t4 errline", err_line, 1);
        send_pix(5, 3, 1'b0, 1'b0, 1'b0);

        // Field start mid-field in continuous mode restarts capture.
        pulse_start(1'b1, 1'b0);
        vsync();
        line(0, 1'b1, H, 1'b0);
        line(1, 1'b1, H, 1'b0);
        line(2, 1'b1, 3, 1'b0);
        vid.iVS = 1'b0;
        exp_done[now + 1] = 1'b1;
        step();
        vid.iVS = 1'b1;
        step();
        chk("t5 errframe", err_frame, 1);
        chk("t5 errline", err_line, 0);
        snap();
        field(1'b1, 1'b1);
        chk("t5 sof", n_sof - s_sof, 1);
        pulse_stop();
        chk("t5 busy", busy, 0);

        // Stop mid-field: field completes, done one cycle after EOF.
        pulse_start(1'b1, 1'b0);
        vsync();
        line(0, 1'b1, H, 1'b0);
        pulse_stop();
        for (int y = 1; y < V; y++) line(y, 1'b1, H, 1'b0);
        exp_done[now + 1] = 1'b1;
        send_pix(0, 0, 1'b0, 1'b0, 1'b0);
        chk("t6 busy", busy, 0);
        vsync();
        line(0, 1'b0, H, 1'b0);

        // Reset in the middle of a field.
        pulse_start(1'b0, 1'b0);
        vsync();
        line(0, 1'b1, H, 1'b0);
        line(1, 1'b1, H, 1'b0);
        line(2, 1'b1, 4, 1'b0);
        rst = 1'b1;
        send_pix(4, 2, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("t7 busy after reset", busy, 0);
        chk("t7 dval after reset", vid.oDVAL, 0);
        chk("t7 done after reset", done, 0);
        idle(2);
        snap();
        pulse_start(1'b0, 1'b0);
        vsync();
        field(1'b1, 1'b1);
        step();
        chk("t7 pixels", n_pix - s_pix, H * V);
        chk("t7 eof", n_eof - s_eof, 1);
        chk("t7 busy", busy, 0);
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/video_capture_ctrl.md
# video_capture_ctrl

Frame-capture sequencer for the video decoding pipeline. It sits after the YCbCr-to-RGB stage on the 27 MHz TV decoder clock and gates the free-running 10-bit RGB stream into whole, aligned fields on software request. It also tags every pixel with x/y coordinates and frame/line markers, skips fields when the consumer is not ready, and reports truncated lines and fields.

## Interface
- H_ACTIVE, 640, pixels per captured line
- V_ACTIVE, 240, lines per captured field
- CNT_W, 8, width of dropped-field counter (saturating)

Ports:
- iCLK  in  1  27 MHz decoder clock
- iRESET  in  1  synchronous reset, active-high (one clock; reset is synchronous and active-high)
- iStart  in  1  one-cycle pulse: arm capture
- iStop  in  1  one-cycle pulse: stop after current field
- iContinuous  in  1  1 = keep capturing fields, 0 = single field; sampled on iStart
- iReady  in  1  consumer can accept a whole field; sampled at field start only
- iVS  in  1  decoder vertical sync, active-low
- iHS  in  1  decoder horizontal sync, active-low
- iR, iG, iB  in  10 each  RGB pixel from converter
- iDVAL  in  1  RGB pixel valid
- oR, oG, oB  out  10 each  registered pixel
- oDVAL  out  1  captured pixel valid
- oX  out  10  pixel column 0..H_ACTIVE-1
- oY  out  9  line 0..V_ACTIVE-1
- oSOF  out  1  with first pixel of field (x=0, y=0)
- oEOL  out  1  with pixel x=H_ACTIVE-1
- oEOF  out  1  with pixel x=H_ACTIVE-1, y=V_ACTIVE-1
- oBusy  out  1  state != IDLE
- oDone  out  1  one-cycle pulse when a field completes or is aborted
- oErrShortLine  out  1  sticky, cleared by iStart
- oErrShortFrame  out  1  sticky, cleared by iStart
- oDropCnt  out  CNT_W  fields skipped for !iReady; saturates; cleared by iStart

## Operation
- Edge detect: registered copies of iVS/iHS; field start = iVS falling edge (1→0); line sync = iHS falling edge.
- States: IDLE, WAIT_VS, ACTIVE, FLUSH.
- IDLE: oDVAL=0. iStart → WAIT_VS; latch iContinuous; clear sticky errors and oDropCnt.
- WAIT_VS: on a field start:
  - iReady=1 → ACTIVE, with x=0 and y=0.
  - iReady=0 → oDropCnt+1; stay in WAIT_VS.
- ACTIVE: each iDVAL pixel is forwarded with the current x/y.
  - x increments per pixel. At x=H_ACTIVE-1, oEOL asserts, x wraps to 0 and y increments.
  - At the last pixel of the field, oEOF and oDone pulse. Next state is WAIT_VS if continuous and no stop is pending, else IDLE.
  - Line sync with x≠0: set oErrShortLine, x←0, y+1. Line sync with x=0: no effect.
  - Line sync that makes y reach V_ACTIVE ends the field with oDone but without oEOF.
  - Field start while in ACTIVE: set oErrShortFrame and pulse oDone. In continuous mode with no stop pending, the same edge starts a new field (iReady check applies). Otherwise → IDLE.
- FLUSH: entered when the field completes while iStop is pending. Lasts one cycle (oDone issued), then → IDLE. Pixels arriving in FLUSH are discarded.
- iStop:
  - In ACTIVE, it latches a stop-pending flag.
  - In WAIT_VS, it goes to IDLE immediately, with no oDone.
  - In IDLE, it is ignored.
- iStart while not IDLE: ignored.
- iStart and iStop in the same cycle from IDLE: start wins; stop is discarded.
- Pixels outside ACTIVE never produce oDVAL.

## Timing
- Pixel latency is 1 cycle: pixel data, oDVAL, oX, oY, oSOF, oEOL and oEOF are all registered together.
- oDone asserts on the same cycle as the oEOF pixel.
- For the abort cases (field-start abort, line-sync field end), oDone asserts 1 cycle after the causing edge is detected.
- Edge detection adds 1 cycle. A pixel that is valid on the same cycle the iVS falling edge is registered is not part of the new field; the first field pixel is the next iDVAL.
- Reset values: all outputs 0, state IDLE, x=y=0, stop-pending=0, latched mode=0.
- Reset asserted mid-field: on the next edge, state is IDLE and oDVAL=0, with no oDone or oEOF.
- oDropCnt holds at 2^CNT_W-1.
- Simultaneous iDVAL and line sync in ACTIVE: the pixel takes the post-sync coordinates (x=0, y+1).

## Test plan
- Single-shot, iReady=1, 640 valid pixels × 240 lines after one iVS fall:
  - exactly 153600 oDVAL pixels;
  - oSOF at (0,0); oEOL 240 times; oEOF and oDone once at (639,239);
  - then oBusy=0.
- Continuous mode, iReady=0 for 3 field starts then 1: oDropCnt=3, and capture starts on the 4th field with oSOF.
- Line with 600 pixels then iHS fall: oErrShortLine=1; next pixel reported at x=0, y=1; field still ends on line count.
- iVS fall after 100 lines, continuous mode: oErrShortFrame=1; oDone pulse; new field begins with oSOF at (0,0).
- iStop at line 50 in continuous mode:
  - the current field completes with oEOF;
  - oDone pulses one cycle later (FLUSH);
  - then IDLE, and no pixels follow.
- iRESET asserted at pixel (320,120): next cycle oDVAL=0, oBusy=0; no oDone; a subsequent iStart captures normally.
